z_seq_detect: RTL and testbench
===============================

// Module: z_seq_detect
//
// PURPOSE
//   Downstream consumer of the gated z output stage.
//   Samples z on every clock edge where en=1 and detects a fixed serial
//   bit pattern in that sample stream.
//   Pulses match for one cycle on each detection. Overlapping detections
//   are allowed.
//   Keeps a sticky seen flag and, optionally, a saturating match counter
//   for bench and debug readout.
//
// PARAMETERS
//   PATTERN_W  4        pattern length in samples (>=2)
//   PATTERN    4'b1011  target pattern; MSB is the oldest sample, LSB the newest
//   CNT_W      8        width of match_cnt (>=1)
//
// PORTS
//   clk        in   1        single clock, rising-edge
//   rst_n      in   1        asynchronous, active-low reset
//   en         in   1        sample qualifier; z is taken only when en=1
//   z          in   1        data bit from the upstream z stage
//   clear      in   1        synchronous clear of history, FSM, seen and counter
//   match      out  1        one-cycle pulse on each pattern detection
//   seen       out  1        sticky; set by the first match
//   match_cnt  out  CNT_W    saturating count of matches
//   filling    out  1        1 while fewer than PATTERN_W samples have been taken
//
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - hist=0, fill_cnt=0, state=S_FILL
//     - match=0, seen=0, match_cnt=0, filling=1
//   Sample: at a posedge with en=1 and clear=0:
//     - hist <= {hist[PATTERN_W-2:0], z}
//     - en=0 freezes everything except match, which returns to 0
//   FSM states (enum from the package):
//     - S_FILL: fill_cnt counts accepted samples. On the sample that makes
//       PATTERN_W samples, go to S_RUN; that sample is also checked for a match.
//     - S_RUN: every accepted sample is checked. Only clear or reset leaves S_RUN.
//   Match check:
//     - next_hist = {hist[PATTERN_W-2:0], z}
//     - match <= (next_hist == PATTERN) && (the sample completes PATTERN_W or more)
//     - Registered output: match is high in the cycle after the completing sample.
//     - Latency 1 clk.
//   Overlap:
//     - No history flush after a match.
//     - Example: 1011011 gives 2 matches.
//   seen:
//     - Set in the same cycle as the first match.
//     - Cleared only by clear or reset.
//   match_cnt:
//     - Incremented in the same cycle as each match.
//     - Holds at 2**CNT_W-1 once there; it never wraps.
//   clear=1:
//     - Next state equals the reset state.
//     - clear has priority over a simultaneous en=1, and that sample is discarded.
//     - match=0 in the following cycle.
//   Reset mid-sequence:
//     - All partial history is lost. A full PATTERN_W-sample refill is
//       required before the next match.
//   filling = (state == S_FILL), a registered decode.
//   Gaps with en=0 do not break a pattern; only accepted samples count.
//
// CONFIGURATION
//   Z_SEQ_MATCH_CNT_EN
//     - Defined: match_cnt is implemented as above.
//     - Undefined: no counter flops are built, and match_cnt is tied to '0.
//     - match and seen behave the same in both cases.
//
// STRUCTURE
//   z_seq_pkg:
//     - typedef enum logic {S_FILL, S_RUN} z_seq_state_e
//     - localparam DEFAULT_PATTERN = 4'b1011
//   Sub-module sat_counter #(W):
//     - ports clk, rst_n, clr, inc, cnt
//     - Saturating up-counter, instantiated only under Z_SEQ_MATCH_CNT_EN.
//   Top level holds the history shift register, fill counter, FSM and output regs.
//
// TESTING (defaults, macro defined; drive en/z/clear on negedge)
//   T1  en=1, z=1,0,1,1 on 4 edges
//       -> match=1 for exactly 1 cycle after the 4th edge; seen=1; match_cnt=1; filling=0
//   T2  en=1, z=1,0,1,1,0,1,1
//       -> two match pulses, 3 cycles apart; match_cnt=2
//   T3  z=1,0,1,1 with en=0 cycles inserted between every sample
//       -> exactly one match, one cycle after the edge carrying the last 1; match_cnt=1
//   T4  z=1,0,1, then clear=1 together with en=1, z=1
//       -> no match; filling=1; match_cnt=0
//       -> 4 further samples 1,0,1,1 then give match_cnt=1
//   T5  rst_n=0 for 10ns in the middle of 1,0,1,1 (after the 2nd sample)
//       -> all outputs 0 immediately with no clock edge; filling=1
//       -> the remaining 1,1 produce no match
//   T6  CNT_W=2, 5 back-to-back non-overlapping 1011 patterns
//       -> match_cnt=3 and holds
//       -> without the macro, match_cnt=0 throughout

Source files
------------

// File: rtl/z_seq_detect_pkg.sv
// Shared types and defaults for the z-stream pattern detector.
package z_seq_pkg;

  typedef enum logic {S_FILL, S_RUN} z_seq_state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/z_seq_detect_if.sv
// Sample/result bundle between the z stage driver and the pattern detector.
interface z_seq_detect_if #(
  parameter int CNT_W = 8
);

  logic             en;
  logic             z;
  logic             clear;
  logic             match;
  logic             seen;
  logic [CNT_W-1:0] match_cnt;
  logic             filling;

  modport master (
    output en, z, clear,
    input  match, seen, match_cnt, filling
  );

  modport slave (
    input  en, z, clear,
    output match, seen, match_cnt, filling
  );

endinterface

// File: rtl/z_seq_detect_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // count register: clear wins, then increment unless already saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/z_seq_detect.sv
// Serial pattern detector on qualified z samples with sticky seen flag.
// Optional saturating match counter is built when Z_SEQ_MATCH_CNT_EN is defined.
module z_seq_detect
  import z_seq_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = DEFAULT_PATTERN,
  parameter int                   CNT_W     = 8
) (
  input logic           clk,
  input logic           rst_n,
  z_seq_detect_if.slave bus
);

  localparam int                FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(PATTERN_W - 1);

  // Only the newest PATTERN_W-1 samples are stored; with z they form the full window.
  logic [PATTERN_W-2:0] hist_r;
  logic [PATTERN_W-2:0] hist_nxt_s;
  logic [PATTERN_W-1:0] window_s;
  logic [FILL_W-1:0]    fill_cnt_r;
  logic [FILL_W-1:0]    fill_cnt_nxt_s;
  z_seq_state_e         state_r;
  z_seq_state_e         state_nxt_s;
  logic                 accept_s;
  logic                 complete_s;
  logic                 hit_s;
  logic                 match_r;
  logic                 seen_r;
  logic                 filling_r;

  // next-state, history shift and match decode
  always_comb begin
    window_s       = {hist_r, bus.z};
    accept_s       = bus.en & ~bus.clear;
    complete_s     = (state_r == S_RUN) || (fill_cnt_r == LAST_FILL);
    hit_s          = accept_s & complete_s & (window_s == PATTERN);
    state_nxt_s    = state_r;
    hist_nxt_s     = hist_r;
    fill_cnt_nxt_s = fill_cnt_r;
    if (bus.clear) begin
      state_nxt_s    = S_FILL;
      hist_nxt_s     = {(PATTERN_W-1){1'b0}};
      fill_cnt_nxt_s = {FILL_W{1'b0}};
    end else if (accept_s) begin
      hist_nxt_s = window_s[PATTERN_W-2:0];
      case (state_r)
        S_FILL: begin
          fill_cnt_nxt_s = fill_cnt_r + FILL_W'(1);
          if (fill_cnt_r == LAST_FILL) begin
            state_nxt_s = S_RUN;
          end else begin
            state_nxt_s = S_FILL;
          end
        end
        S_RUN: begin
          state_nxt_s = S_RUN;
        end
        default: begin
          state_nxt_s = S_FILL;
        end
      endcase
    end else begin
      state_nxt_s    = state_r;
      hist_nxt_s     = hist_r;
      fill_cnt_nxt_s = fill_cnt_r;
    end
  end

  // state, history and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_FILL;
      hist_r     <= {(PATTERN_W-1){1'b0}};
      fill_cnt_r <= {FILL_W{1'b0}};
      match_r    <= 1'b0;
      seen_r     <= 1'b0;
      filling_r  <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      hist_r     <= hist_nxt_s;
      fill_cnt_r <= fill_cnt_nxt_s;
      match_r    <= hit_s;
      seen_r     <= bus.clear ? 1'b0 : (seen_r | hit_s);
      filling_r  <= (state_nxt_s == S_FILL);
    end
  end

  assign bus.match   = match_r;
  assign bus.seen    = seen_r;
  assign bus.filling = filling_r;

`ifdef Z_SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_s;

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (hit_s),
    .cnt   (cnt_s)
  );

  assign bus.match_cnt = cnt_s;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_z_seq_detect.sv
// Directed bench for z_seq_detect: default instance plus a CNT_W=2 instance for saturation.
module tb_z_seq_detect;

`ifdef Z_SEQ_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  z_seq_detect_if #(.CNT_W(8)) bus1 ();
  z_seq_detect_if #(.CNT_W(2)) bus2 ();

  z_seq_detect #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  z_seq_detect #(.CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ecnt(input int n, input int maxv);
    if (!CNT_ON) return 0;
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic e, input logic zz, input logic c);
    @(negedge clk);
    bus1.en    = e;
    bus1.z     = zz;
    bus1.clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic tick2(input logic e, input logic zz, input logic c);
    @(negedge clk);
    bus2.en    = e;
    bus2.z     = zz;
    bus2.clear = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] t2_z;
    logic [6:0] t2_m;
    logic [3:0] pat;
    n_vec = 0;
    n_err = 0;
    t2_z  = 7'b1011011;
    t2_m  = 7'b0001001;
    pat   = 4'b1011;
    rst_n = 1'b0;
    bus1.en = 1'b0; bus1.z = 1'b0; bus1.clear = 1'b0;
    bus2.en = 1'b0; bus2.z = 1'b0; bus2.clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", bus1.match, 32'd0);
    chk("rst_seen", bus1.seen, 32'd0);
    chk("rst_cnt", bus1.match_cnt, 32'd0);
    chk("rst_filling", bus1.filling, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: single 1011
    tick(1'b1, 1'b1, 1'b0);
    chk("t1_s1_match", bus1.match, 32'd0);
    chk("t1_s1_filling", bus1.filling, 32'd1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("t1_s3_match", bus1.match, 32'd0);
    tick(1'b1, 1'b1, 1'b0);
    chk("t1_match", bus1.match, 32'd1);
    chk("t1_seen", bus1.seen, 32'd1);
    chk("t1_cnt", bus1.match_cnt, 32'(ecnt(1, 255)));
    chk("t1_filling", bus1.filling, 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("t1_pulse_end", bus1.match, 32'd0);
    chk("t1_seen_sticky", bus1.seen, 32'd1);
    tick(1'b0, 1'b0, 1'b1);
    chk("clr_seen", bus1.seen, 32'd0);
    chk("clr_cnt", bus1.match_cnt, 32'd0);
    chk("clr_filling", bus1.filling, 32'd1);

    // T2: overlapping 1011011
    for (int i = 6; i >= 0; i--) begin
      tick(1'b1, t2_z[i], 1'b0);
      chk("t2_match", bus1.match, 32'(t2_m[i]));
    end
    chk("t2_cnt", bus1.match_cnt, 32'(ecnt(2, 255)));
    tick(1'b0, 1'b0, 1'b1);

    // T3: en=0 gaps, z toggling during gaps must be ignored
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("t3_gap_match", bus1.match, 32'd0);
    tick(1'b1, 1'b1, 1'b0);
    chk("t3_match", bus1.match, 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    chk("t3_pulse_end", bus1.match, 32'd0);
    chk("t3_cnt", bus1.match_cnt, 32'(ecnt(1, 255)));
    tick(1'b0, 1'b0, 1'b1);

    // T4: clear beats a simultaneous sample
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    chk("t4_clr_match", bus1.match, 32'd0);
    chk("t4_clr_filling", bus1.filling, 32'd1);
    chk("t4_clr_cnt", bus1.match_cnt, 32'd0);
    for (int i = 3; i >= 0; i--) begin
      tick(1'b1, pat[i], 1'b0);
      chk("t4_refill_match", bus1.match, (i == 0) ? 32'd1 : 32'd0);
    end
    chk("t4_cnt", bus1.match_cnt, 32'(ecnt(1, 255)));

    // T5: async reset mid-sequence
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus1.en = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("t5_rst_match", bus1.match, 32'd0);
    chk("t5_rst_seen", bus1.seen, 32'd0);
    chk("t5_rst_cnt", bus1.match_cnt, 32'd0);
    chk("t5_rst_filling", bus1.filling, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    chk("t5_s3_match", bus1.match, 32'd0);
    tick(1'b1, 1'b1, 1'b0);
    chk("t5_s4_match", bus1.match, 32'd0);
    chk("t5_filling", bus1.filling, 32'd1);
    tick(1'b0, 1'b0, 1'b0);

    // T6: CNT_W=2 saturation over five back-to-back patterns
    for (int k = 1; k <= 5; k++) begin
      for (int i = 3; i >= 0; i--) begin
        tick2(1'b1, pat[i], 1'b0);
      end
      chk("t6_match", bus2.match, 32'd1);
      chk("t6_cnt", bus2.match_cnt, 32'(ecnt(k, 3)));
    end
    tick2(1'b0, 1'b0, 1'b0);
    tick2(1'b0, 1'b0, 1'b0);
    chk("t6_hold", bus2.match_cnt, 32'(ecnt(5, 3)));
    chk("t6_seen", bus2.seen, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
